// File: rtl/seq_player_ctrl.sv
// Pattern sequence player: selects one of 2^SEQ_BITS ROM sequences with push buttons and
// steps through its words on step_tick, stopping early on END_MARK.
module seq_player_ctrl #(
  parameter int unsigned SEQ_BITS  = 4,
  parameter int unsigned STEP_BITS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter logic [DATA_W-1:0] END_MARK = {DATA_W{1'b1}}
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic                          pb_seq_up,
  input  logic                          pb_seq_dn,
  input  logic                          pb_play,
  input  logic                          step_tick,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [SEQ_BITS+STEP_BITS-1:0] rom_addr,
  output logic [SEQ_BITS-1:0]           seq_num,
  output logic [STEP_BITS-1:0]          step_num,
  output logic [DATA_W-1:0]             pattern_out,
  output logic                          pattern_valid,
  output logic                          playing
);

  typedef enum logic [1:0] {StIdle, StFetch, StLatch, StWait} state_e;

  state_e                state_q, state_d;
  logic [SEQ_BITS-1:0]   seq_q, seq_d;
  logic [STEP_BITS-1:0]  step_q, step_d;
  logic [DATA_W-1:0]     pattern_q, pattern_d;
  logic                  valid_q, valid_d;
  logic                  up_prev_q, dn_prev_q, play_prev_q;
  logic                  armed_q;

  logic                  up_edge, dn_edge, play_edge, seq_change;
  logic [SEQ_BITS-1:0]   seq_next;

  // armed_q masks edges on the first cycle after reset so a held button is not seen as a press.
  assign up_edge    = armed_q & pb_seq_up & ~up_prev_q;
  assign dn_edge    = armed_q & pb_seq_dn & ~dn_prev_q;
  assign play_edge  = armed_q & pb_play   & ~play_prev_q;
  assign seq_change = up_edge ^ dn_edge;
  assign seq_next   = up_edge ? seq_q + SEQ_BITS'(1) : seq_q - SEQ_BITS'(1);

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      seq_q       <= '0;
      step_q      <= '0;
      pattern_q   <= '0;
      valid_q     <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      play_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      step_q      <= step_d;
      pattern_q   <= pattern_d;
      valid_q     <= valid_d;
      up_prev_q   <= pb_seq_up;
      dn_prev_q   <= pb_seq_dn;
      play_prev_q <= pb_play;
      armed_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    step_d    = step_q;
    pattern_d = pattern_q;
    valid_d   = 1'b0;

    if (seq_change) begin
      seq_d  = seq_next;
      step_d = '0;
    end

    if (state_q == StIdle) begin
      if (play_edge) begin
        state_d = StFetch;
        step_d  = '0;
      end
    end else if (play_edge) begin
      // Stop wins over a simultaneous sequence change; step is only cleared by that change.
      state_d = StIdle;
    end else if (seq_change) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: state_d = StLatch;
        StLatch: begin
          if (rom_data != END_MARK) begin
            pattern_d = rom_data;
            valid_d   = 1'b1;
            state_d   = StWait;
          end else if (step_q != '0) begin
            step_d  = '0;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
        StWait: begin
          if (step_tick) begin
            step_d  = step_q + STEP_BITS'(1);
            state_d = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rom_addr      = {seq_q, step_q};
  assign seq_num       = seq_q;
  assign step_num      = step_q;
  assign pattern_out   = pattern_q;
  assign pattern_valid = valid_q;
  assign playing       = (state_q != StIdle);

endmodule

// File: tb/tb_seq_player_ctrl.sv
// Bench for seq_player_ctrl: directed scenarios plus random sequences checked against a
// sequence-level model of the pattern ROM walk.
module tb_seq_player_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       pb_seq_up, pb_seq_dn, pb_play, step_tick;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  logic [3:0] seq_num, step_num;
  logic [7:0] pattern_out;
  logic       pattern_valid, playing;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rom_mem [256];
  int         m_seq;
  logic [7:0] m_pat;

  always #5 clk_50 = ~clk_50;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk_50) rom_data <= rom_mem[rom_addr];

  seq_player_ctrl dut (
    .clk_50        (clk_50),
    .reset         (reset),
    .pb_seq_up     (pb_seq_up),
    .pb_seq_dn     (pb_seq_dn),
    .pb_play       (pb_play),
    .step_tick     (step_tick),
    .rom_data      (rom_data),
    .rom_addr      (rom_addr),
    .seq_num       (seq_num),
    .step_num      (step_num),
    .pattern_out   (pattern_out),
    .pattern_valid (pattern_valid),
    .playing       (playing)
  );

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // 0 up, 1 dn, 2 play, 3 up+dn together; one-cycle press then release.
  task automatic press(input int which);
    case (which)
      0: pb_seq_up = 1'b1;
      1: pb_seq_dn = 1'b1;
      2: pb_play   = 1'b1;
      default: begin
        pb_seq_up = 1'b1;
        pb_seq_dn = 1'b1;
      end
    endcase
    step();
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    pb_play   = 1'b0;
    step();
  endtask

  task automatic goto_seq(input int target);
    int guard = 0;
    while (m_seq != target && guard < 32) begin
      press(0);
      m_seq = (m_seq + 1) % 16;
      guard++;
    end
    chk("goto_seq", seq_num, target);
  endtask

  // Strobe play or step_tick, then measure cycles until the pattern_valid pulse.
  task automatic fire_expect(input bit use_play, input logic [7:0] exp, input int exp_lat,
                             input string tag);
    int n;
    if (use_play) pb_play = 1'b1;
    else step_tick = 1'b1;
    step();
    pb_play   = 1'b0;
    step_tick = 1'b0;
    n = 1;
    while (!pattern_valid && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, pattern_valid, 1);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_pat"}, pattern_out, exp);
    step();
    chk({tag, "_pulse"}, pattern_valid, 0);
    m_pat = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, len, nt, k, lat, np;
    reset     = 1'b0;
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
    pb_play   = 1'b0;
    step_tick = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom_range(0, 254));
    rom_mem[0]  = 8'h11;
    rom_mem[1]  = 8'h22;
    rom_mem[2]  = 8'hFF;
    rom_mem[48] = 8'hFF;
    m_seq = 0;
    m_pat = 8'h00;

    // Reset state, with buttons held high through release.
    pb_play   = 1'b1;
    pb_seq_up = 1'b1;
    repeat (3) step();
    chk("rst_addr", rom_addr, 0);
    chk("rst_seq", seq_num, 0);
    chk("rst_step", step_num, 0);
    chk("rst_pat", pattern_out, 0);
    chk("rst_valid", pattern_valid, 0);
    chk("rst_playing", playing, 0);
    reset = 1'b1;
    repeat (4) step();
    chk("held_playing", playing, 0);
    chk("held_seq", seq_num, 0);
    pb_play   = 1'b0;
    pb_seq_up = 1'b0;
    repeat (2) step();

    // Three ups, one down.
    repeat (3) press(0);
    press(1);
    m_seq = 2;
    chk("sel_seq", seq_num, 2);
    chk("sel_step", step_num, 0);
    chk("sel_addr", rom_addr, 8'h20);
    chk("sel_playing", playing, 0);

    // Down wrap from 0.
    press(1);
    press(1);
    press(1);
    m_seq = 15;
    chk("wrap_dn", seq_num, 15);
    goto_seq(0);

    // Sequence 0 with early END_MARK wraps back to step 0.
    fire_expect(1'b1, 8'h11, 3, "s0_play");
    chk("s0_playing", playing, 1);
    fire_expect(1'b0, 8'h22, 3, "s0_t1");
    fire_expect(1'b0, 8'h11, 5, "s0_t2");
    chk("s0_step", step_num, 0);
    fire_expect(1'b0, 8'h22, 3, "s0_t3");
    press(2);
    chk("stop_playing", playing, 0);
    chk("stop_step", step_num, 1);
    chk("stop_pat", pattern_out, 8'h22);

    // Tick while idle is ignored.
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    repeat (3) step();
    chk("idle_tick_step", step_num, 1);
    chk("idle_tick_valid", pattern_valid, 0);

    // Sequence 1: full 16-step walk with natural wrap.
    goto_seq(1);
    chk("seq_chg_step", step_num, 0);
    fire_expect(1'b1, rom_mem[16], 3, "s1_play");
    for (int i = 1; i <= 16; i++) begin
      fire_expect(1'b0, rom_mem[16 + (i % 16)], 3, "s1_tick");
      if (i == 15) begin
        chk("s1_step15", step_num, 15);
        chk("s1_addr1f", rom_addr, 8'h1F);
      end
      if (i == 16) begin
        chk("s1_step0", step_num, 0);
        chk("s1_addr10", rom_addr, 8'h10);
      end
    end
    press(2);

    // Sequence 3 is empty: falls back to idle without a pulse.
    goto_seq(3);
    pb_play = 1'b1;
    step();
    pb_play = 1'b0;
    np = 0;
    repeat (2) begin
      step();
      if (pattern_valid) np++;
    end
    step();
    if (pattern_valid) np++;
    chk("empty_playing", playing, 0);
    chk("empty_pat", pattern_out, m_pat);
    chk("empty_nopulse", np, 0);

    // Simultaneous up/dn in WAIT is ignored.
    goto_seq(4);
    fire_expect(1'b1, rom_mem[64], 3, "s4_play");
    fire_expect(1'b0, rom_mem[65], 3, "s4_t1");
    press(3);
    chk("both_seq", seq_num, 4);
    chk("both_step", step_num, 1);
    chk("both_playing", playing, 1);
    chk("both_valid", pattern_valid, 0);
    fire_expect(1'b0, rom_mem[66], 3, "s4_t2");
    for (int i = 3; i <= 5; i++) fire_expect(1'b0, rom_mem[64 + i], 3, "s4_tn");
    chk("s4_step5", step_num, 5);

    // Seq change while playing restarts at step 0.
    press(0);
    m_seq = 5;
    chk("play_chg_seq", seq_num, 5);
    repeat (3) step();
    chk("play_chg_step", step_num, 0);
    chk("play_chg_pat", pattern_out, rom_mem[80]);
    goto_seq(4);
    repeat (3) step();
    for (int i = 1; i <= 5; i++) fire_expect(1'b0, rom_mem[64 + i], 3, "s4_re");

    // Asynchronous reset mid-sequence.
    reset = 1'b0;
    #2;
    chk("arst_addr", rom_addr, 0);
    chk("arst_seq", seq_num, 0);
    chk("arst_step", step_num, 0);
    chk("arst_pat", pattern_out, 0);
    chk("arst_valid", pattern_valid, 0);
    chk("arst_playing", playing, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    chk("arst_rel_playing", playing, 0);
    m_seq = 0;
    m_pat = 8'h00;
    fire_expect(1'b1, 8'h11, 3, "arst_play");
    chk("arst_play_addr", rom_addr, 8'h00);
    press(2);
    chk("arst_stop", playing, 0);

    // Random sequences of random length against the ROM-walk model.
    for (int r = 0; r < 6; r++) begin
      s   = $urandom_range(5, 15);
      len = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) begin
        if (i < len) rom_mem[s * 16 + i] = 8'($urandom_range(0, 254));
        else if (i == len) rom_mem[s * 16 + i] = 8'hFF;
      end
      nt = $urandom_range(0, 6);
      for (int i = 0; i < nt; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          press(0);
          m_seq = (m_seq + 1) % 16;
        end else begin
          press(1);
          m_seq = (m_seq + 15) % 16;
        end
      end
      chk("rnd_sel_seq", seq_num, m_seq);
      chk("rnd_sel_step", step_num, 0);
      goto_seq(s);
      fire_expect(1'b1, rom_mem[s * 16], 3, "rnd_play");
      nt = $urandom_range(4, 20);
      for (k = 1; k <= nt; k++) begin
        repeat ($urandom_range(0, 2)) step();
        lat = ((k % len) == 0 && len < 16) ? 5 : 3;
        fire_expect(1'b0, rom_mem[s * 16 + (k % len)], lat, "rnd_tick");
        chk("rnd_step", step_num, k % len);
      end
      press(2);
      chk("rnd_stop", playing, 0);
      chk("rnd_hold_pat", pattern_out, m_pat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
